bin2bcd_seq: RTL and testbench
==============================

Name: bin2bcd_seq

Overview:
- Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock.
- Sits directly upstream of the 4-digit multiplexed seven-segment driver.
- Converts a CPU result (e.g. GCD output or a memory-mapped display register) into the packed 16-bit digit bus `seg_data_16`.
- Uses a start/busy/done handshake, so CPU-side logic never needs a combinational divide or modulo.

Parameters:
- BIN_W, 16: width of the binary input; also the number of shift cycles.
- DIGITS, 4: number of BCD digits produced; output width is 4*DIGITS.

Ports:
- clk  input  1  system clock (100 MHz)
- rst_n  input  1  reset; one clock, asynchronous, active-low
- start  input  1  request a conversion; sampled only in IDLE
- bin_in  input  BIN_W  binary value; captured on the accepted start cycle
- busy  output  1  high while a conversion is in progress
- done  output  1  one-cycle pulse when bcd_out/overflow are updated
- bcd_out  output  4*DIGITS  packed digits; [3:0] = least significant; maps directly onto seg_data_16
- overflow  output  1  last conversion's bin_in was >= 10^DIGITS

Behaviour:
- Reset, asynchronous on rst_n low:
  - State = IDLE.
  - busy=0, done=0, overflow=0, bcd_out=0.
  - Internal shift register and counter cleared.
- States: IDLE, SHIFT, FINISH.
- IDLE:
  - start=1 latches bin_in into the shift register and clears the BCD scratch.
  - Loads counter = BIN_W.
  - Computes ovf_pend = (bin_in >= 10^DIGITS), with the comparison at BIN_W+1 bits.
  - Goes to SHIFT; busy=1 from the next cycle.
- SHIFT, each cycle:
  - Every scratch digit >= 5 gets +3 (4-bit, no carry between digits).
  - Then {scratch, shift} shifts left by 1.
  - Counter decrements; when it reaches 0 after the shift, go to FINISH.
- FINISH, one cycle:
  - bcd_out <= scratch, or all digits 4'hF if ovf_pend.
  - overflow <= ovf_pend.
  - done=1, busy=0 on the next edge; return to IDLE.
- Latency: start accepted at edge N; done high and bcd_out valid in the cycle after edge N+BIN_W+1, i.e. 17 cycles for BIN_W=16.
- Throughput: one conversion per BIN_W+2 cycles. start is legal in the cycle done is high, which is IDLE.
- Handshake rules:
  - start while busy=1 is ignored: no queueing, no restart, bin_in not re-sampled.
  - start held high continuously starts back-to-back conversions.
- bcd_out and overflow hold their values between conversions; only FINISH updates them. The downstream display never sees partial results.
- Overflow blanking: all-4'hF digits make the display's default decode blank every digit.
- Reset mid-conversion aborts immediately. No done pulse is produced; outputs return to reset values.
- Digit adjust is purely combinational per digit. The scratch is 4*DIGITS bits; any bit shifted out of the top digit is discarded, since overflow is already known.

Optional Feature:
- Macro: BIN2BCD_LEADING_ZERO_BLANK_EN.
- When defined, in FINISH (non-overflow case), leading zero digits above digit 0 are replaced by 4'hF. Scanning runs from the most significant digit down and stops at the first nonzero digit. Digit 0 is always shown. Example: 42 gives 16'hFF42.
- When undefined, all digits are output as-is. Example: 42 gives 16'h0042.
- Latency is the same in both builds.

Decomposition:
- Shared package (bin2bcd_pkg):
  - state encoding: IDLE=2'd0, SHIFT=2'd1, FINISH=2'd2
  - DIGIT_BLANK = 4'hF
  - function pow10(DIGITS) for the overflow threshold
- One natural sub-module: bcd_add3_digit, a 4-bit combinational adjust (in >= 5 ? in+3 : in), instantiated DIGITS times via generate.

Test Plan:
- bin_in=1234, start pulse at cycle 0 -> busy cycles 1..17; done pulse 17 cycles after start; bcd_out=16'h1234; overflow=0.
- bin_in=0, then bin_in=9999 -> bcd_out=16'h0000, then 16'h9999. With BIN2BCD_LEADING_ZERO_BLANK_EN, the 0 case gives 16'hFFF0.
- bin_in=10000, then 65535 -> overflow=1 and bcd_out=16'hFFFF both times. A following 7 gives overflow=0 and bcd_out=16'h0007.
- start bin_in=500, then pulse start with bin_in=321 at cycle 5 -> second start ignored; single done; bcd_out=16'h0500.
- start bin_in=77, assert rst_n=0 at cycle 8 for 2 cycles -> no done; bcd_out=0, busy=0. A new start bin_in=88 then gives 16'h0088 with normal latency.
- start held high for 40 cycles with bin_in=12 -> done pulses exactly BIN_W+2 cycles apart; bcd_out stays 16'h0012.

Source files
------------

// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_e;

  localparam logic [3:0] DIGIT_BLANK = 4'hF;

  // Overflow threshold: the first value that needs more than n decimal digits.
  function automatic int unsigned pow10(input int unsigned n);
    int unsigned r;
    r = 1;
    for (int unsigned i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Start/busy/done handshake bundle between the value producer and bin2bcd_seq.
// start is sampled only while the converter is idle; done pulses one cycle when bcd_out/overflow update.
interface bin2bcd_seq_if #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 4
);
  logic                  start;
  logic [BIN_W-1:0]      bin_in;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd_out;
  logic                  overflow;
  logic [1:0]            state_dbg;

  modport master (
    output start, bin_in,
    input  busy, done, bcd_out, overflow, state_dbg
  );

  modport slave (
    input  start, bin_in,
    output busy, done, bcd_out, overflow, state_dbg
  );
endinterface

// File: rtl/bcd_add3_digit.sv
// Double-dabble digit adjust: add 3 to a BCD digit that is 5 or more.
module bcd_add3_digit (
  input  logic [3:0] din,
  output logic [3:0] dout
);
  assign dout = (din >= 4'd5) ? din + 4'd3 : din;
endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// Define BIN2BCD_LEADING_ZERO_BLANK_EN to blank leading zero digits above digit 0.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  bin2bcd_seq_if.slave  bus
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [BIN_W:0] OVF_THRESH = (BIN_W + 1)'(pow10(DIGITS));

  state_e             state_q, state_d;
  logic [BIN_W-1:0]   shift_q, shift_d;
  logic [BCD_W-1:0]   scratch_q, scratch_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_pend_q, ovf_pend_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               overflow_q, overflow_d;

  logic [BCD_W-1:0]   scratch_adj;
  logic [BCD_W-1:0]   fin_digits;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_add3_digit u_adj (
      .din  (scratch_q[4*g +: 4]),
      .dout (scratch_adj[4*g +: 4])
    );
  end

`ifdef BIN2BCD_LEADING_ZERO_BLANK_EN
  // Scan from the top digit down; blank zeros until the first nonzero digit.
  always_comb begin
    logic leading;
    leading    = 1'b1;
    fin_digits = scratch_q;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (leading && (scratch_q[4*i +: 4] == 4'd0)) begin
        fin_digits[4*i +: 4] = DIGIT_BLANK;
      end else begin
        leading = 1'b0;
      end
    end
  end
`else
  assign fin_digits = scratch_q;
`endif

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    scratch_d  = scratch_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    bcd_d      = bcd_q;
    overflow_d = overflow_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          shift_d    = bus.bin_in;
          scratch_d  = '0;
          cnt_d      = CNT_W'(BIN_W);
          ovf_pend_d = ({1'b0, bus.bin_in} >= OVF_THRESH);
          busy_d     = 1'b1;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        // The bit leaving the top digit is dropped; overflow was decided at capture.
        {scratch_d, shift_d} = {scratch_adj, shift_q} << 1;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = FINISH;
      end
      FINISH: begin
        bcd_d      = ovf_pend_q ? {DIGITS{DIGIT_BLANK}} : fin_digits;
        overflow_d = ovf_pend_q;
        done_d     = 1'b1;
        busy_d     = 1'b0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      scratch_q  <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      bcd_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      scratch_q  <= scratch_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      bcd_q      <= bcd_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.bcd_out   = bcd_q;
  assign bus.overflow  = overflow_q;
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Randomized self-checking bench for bin2bcd_seq against a decimal-arithmetic reference.
module tb_bin2bcd_seq;

  localparam int BIN_W  = 16;
  localparam int DIGITS = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  bin2bcd_seq_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) bus ();

  bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: decimal digits by division, overflow blanks all digits.
  function automatic logic [15:0] ref_bcd(input int unsigned v);
    logic [15:0] r;
    int unsigned x;
    if (v >= 10000) return 16'hFFFF;
    x = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
`ifdef BIN2BCD_LEADING_ZERO_BLANK_EN
    begin
      bit lead;
      lead = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) begin
        if (lead && r[4*i +: 4] == 4'd0) r[4*i +: 4] = 4'hF;
        else lead = 1'b0;
      end
    end
`endif
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one conversion and check latency, busy window, result and hold.
  task automatic run_conv(input int unsigned v);
    int k;
    int busy_cnt;
    bit seen;
    logic [15:0] exp_v;
    bus.bin_in = 16'(v);
    bus.start  = 1'b1;
    exp_q.push_back(ref_bcd(v));
    tick();
    bus.start  = 1'b0;
    bus.bin_in = 16'($urandom);
    k = 0;
    busy_cnt = bus.busy ? 1 : 0;
    seen = 1'b0;
    while (!seen && k < 40) begin
      tick();
      k++;
      if (bus.done) seen = 1'b1;
      else if (bus.busy) busy_cnt++;
    end
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (!seen) begin
      n_err++;
      $display("FAIL conv_timeout v=%0d: no done within %0d cycles", v, k);
    end else begin
      n_cmp++;
      if (k !== BIN_W + 1) begin
        n_err++;
        $display("FAIL latency v=%0d: got %0d want %0d", v, k, BIN_W + 1);
      end
      n_cmp++;
      if (busy_cnt !== BIN_W + 1 || bus.busy !== 1'b0) begin
        n_err++;
        $display("FAIL busy_window v=%0d: busy cycles %0d (busy at done %b) want %0d", v, busy_cnt, bus.busy, BIN_W + 1);
      end
      n_cmp++;
      if (bus.bcd_out !== exp_v) begin
        n_err++;
        $display("FAIL bcd_out v=%0d: got %h want %h", v, bus.bcd_out, exp_v);
      end
      n_cmp++;
      if (bus.overflow !== (v >= 10000)) begin
        n_err++;
        $display("FAIL overflow v=%0d: got %b want %b", v, bus.overflow, (v >= 10000));
      end
      tick();
      n_cmp++;
      if (bus.done !== 1'b0 || bus.bcd_out !== exp_v) begin
        n_err++;
        $display("FAIL hold v=%0d: done %b bcd %h want done 0 bcd %h", v, bus.done, bus.bcd_out, exp_v);
      end
    end
  endtask

  task automatic test_reset();
    bus.start  = 1'b0;
    bus.bin_in = '0;
    rst_n      = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.bcd_out !== 16'h0000 ||
        bus.overflow !== 1'b0 || bus.state_dbg !== 2'd0) begin
      n_err++;
      $display("FAIL reset_state: busy %b done %b bcd %h ovf %b state %0d want all zero",
               bus.busy, bus.done, bus.bcd_out, bus.overflow, bus.state_dbg);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    run_conv(1234);
    run_conv(0);
    run_conv(9999);
  endtask

  task automatic test_overflow();
    run_conv(10000);
    run_conv(65535);
    run_conv(7);
  endtask

  task automatic test_ignore_start();
    int nd;
    int at;
    logic [15:0] exp_v;
    exp_v = ref_bcd(500);
    nd = 0;
    at = -1;
    bus.bin_in = 16'd500;
    bus.start  = 1'b1;
    tick();
    for (int i = 1; i <= 40; i++) begin
      if (i == 5) begin
        bus.start  = 1'b1;
        bus.bin_in = 16'd321;
      end else begin
        bus.start = 1'b0;
      end
      tick();
      if (bus.done) begin
        nd++;
        at = i;
        n_cmp++;
        if (bus.bcd_out !== exp_v) begin
          n_err++;
          $display("FAIL ignore_start_value: got %h want %h", bus.bcd_out, exp_v);
        end
      end
    end
    n_cmp++;
    if (nd !== 1 || at !== BIN_W + 1) begin
      n_err++;
      $display("FAIL ignore_start_count: got %0d dones (last at %0d) want 1 at %0d", nd, at, BIN_W + 1);
    end
  endtask

  task automatic test_reset_mid();
    int bad_done;
    bus.bin_in = 16'd77;
    bus.start  = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (7) tick();
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.bcd_out !== 16'h0000 ||
        bus.overflow !== 1'b0 || bus.state_dbg !== 2'd0) begin
      n_err++;
      $display("FAIL reset_mid_outputs: busy %b done %b bcd %h ovf %b state %0d want all zero",
               bus.busy, bus.done, bus.bcd_out, bus.overflow, bus.state_dbg);
    end
    bad_done = 0;
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (bus.done || bus.busy) bad_done++;
    end
    n_cmp++;
    if (bad_done !== 0 || bus.bcd_out !== 16'h0000) begin
      n_err++;
      $display("FAIL reset_mid_abort: %0d cycles with done/busy, bcd %h want 0 and 0000", bad_done, bus.bcd_out);
    end
    run_conv(88);
  endtask

  task automatic test_back_to_back();
    int nd;
    int last;
    int k;
    logic [15:0] exp_v;
    exp_v = ref_bcd(12);
    nd = 0;
    last = -1;
    bus.bin_in = 16'd12;
    bus.start  = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (bus.done) begin
        n_cmp++;
        if (bus.bcd_out !== exp_v) begin
          n_err++;
          $display("FAIL b2b_value: got %h want %h", bus.bcd_out, exp_v);
        end
        if (last >= 0) begin
          n_cmp++;
          if (i - last !== BIN_W + 2) begin
            n_err++;
            $display("FAIL b2b_spacing: got %0d want %0d", i - last, BIN_W + 2);
          end
        end
        last = i;
        nd++;
      end
    end
    n_cmp++;
    if (nd !== 2) begin
      n_err++;
      $display("FAIL b2b_count: got %0d dones want 2", nd);
    end
    bus.start = 1'b0;
    k = 0;
    while (bus.busy && k < 40) begin
      tick();
      k++;
    end
    tick();
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.bcd_out !== exp_v) begin
      n_err++;
      $display("FAIL b2b_drain: busy %b bcd %h want 0 and %h", bus.busy, bus.bcd_out, exp_v);
    end
  endtask

  task automatic test_random();
    int unsigned v;
    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(0, 3) == 0) v = $urandom_range(0, 65535);
      else v = $urandom_range(0, 9999);
      run_conv(v);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
